// File: rtl/hazard_halt_ctrl_pkg.sv
// Shared pipeline-control definitions.
// Contents:
//   state_t          - hazard/halt controller state encoding
//   REG_ZERO         - architectural x0 index (never a real dependency)
//   DRAIN_CYCLES_DEF - default number of bubble cycles after a halt
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/hazard_halt_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/halt controller.
// master : pipeline side; drives ID/EX status, receives enables/flushes.
// slave  : controller side; receives status, drives enables/flushes,
//          halted and the stall performance counter.
interface hazard_halt_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_halt;
  logic             ex_valid;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_halt,
    output ex_valid, ex_mem_read, ex_rd, ex_redirect,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_halt,
    input  ex_valid, ex_mem_read, ex_rd, ex_redirect,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_halt_ctrl_load_use.sv
// load_use_detect: combinational load-use hazard comparator.
// Ports:
//   ex_valid, ex_mem_read, ex_rd : EX-stage instruction status
//   id_valid, id_rs1, id_rs2     : ID-stage instruction sources
//   luse                         : ID needs the result of the EX load
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       luse
);
  // A load targeting x0 produces nothing, so it can never cause a stall.
  assign luse = ex_valid & ex_mem_read & (ex_rd != REG_ZERO) & id_valid &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));
endmodule

// File: rtl/hazard_halt_ctrl.sv
// hazard_halt_ctrl: PC / IF-ID enables and flush/bubble controls for a
// 5-stage RV32I pipeline. Handles load-use stalls, EX redirect flushes and
// the halt drain sequence, and counts load-use stall cycles (saturating).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - hazard_halt_ctrl_if.slave (status in, controls/counter out)
module hazard_halt_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_halt_ctrl_if.slave  bus
);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t           fsm_reg, fsm_next;
  logic [3:0]       dcnt_reg, dcnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             stall_inc;
  logic             luse;

  logic pc_write, if_id_write, if_id_flush, id_ex_flush, halted;

  load_use_detect u_luse (
    .ex_valid    (bus.ex_valid),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_valid    (bus.id_valid),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .luse        (luse)
  );

  always_comb begin
    fsm_next    = fsm_reg;
    dcnt_next   = dcnt_reg;
    stall_inc   = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    case (fsm_reg)
      RUN: begin
        if (bus.ex_redirect) begin
          // ID holds a wrong-path instruction: its halt/hazard is moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (luse) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else if (bus.id_valid && bus.id_halt) begin
          // The halt itself enters EX as a bubble; older work drains.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          fsm_next    = DRAIN;
          dcnt_next   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (dcnt_reg == 4'd0) begin
          fsm_next = HALTED;
        end else begin
          dcnt_next = dcnt_reg - 4'd1;
        end
      end
      HALTED: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        fsm_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= RUN;
      dcnt_reg      <= 4'd0;
      stall_cnt_reg <= '0;
    end else begin
      fsm_reg  <= fsm_next;
      dcnt_reg <= dcnt_next;
      if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.if_id_write = if_id_write;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.halted      = halted;
  assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_halt_ctrl.sv
// Scoreboard bench for hazard_halt_ctrl. Inputs are applied 1 ns after the
// rising edge and the expected response is queued; a monitor on the falling
// edge pops and compares. Two instances: default width, and CNT_W=4 for
// counter saturation.
module tb_hazard_halt_ctrl;

  localparam logic [4:0] NORM  = 5'b11000; // {pc_w, ifid_w, ifid_fl, idex_fl, halted}
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] REDIR = 5'b11110;
  localparam logic [4:0] DRN   = 5'b00110;
  localparam logic [4:0] HLT   = 5'b00111;

  typedef struct {
    string       name;
    bit          sel;
    logic [4:0]  ctl;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_total;
  int   n_pass;

  hazard_halt_ctrl_if #(.CNT_W(32)) m_if ();
  hazard_halt_ctrl_if #(.CNT_W(4))  s_if ();

  hazard_halt_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  hazard_halt_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_m(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic hlt, input logic exv, input logic mr,
                       input logic [4:0] rd, input logic red);
    m_if.id_valid    = idv;
    m_if.id_rs1      = rs1;
    m_if.id_rs2      = rs2;
    m_if.id_halt     = hlt;
    m_if.ex_valid    = exv;
    m_if.ex_mem_read = mr;
    m_if.ex_rd       = rd;
    m_if.ex_redirect = red;
  endtask

  task automatic drv_s(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic hlt, input logic exv, input logic mr,
                       input logic [4:0] rd, input logic red);
    s_if.id_valid    = idv;
    s_if.id_rs1      = rs1;
    s_if.id_rs2      = rs2;
    s_if.id_halt     = hlt;
    s_if.ex_valid    = exv;
    s_if.ex_mem_read = mr;
    s_if.ex_rd       = rd;
    s_if.ex_redirect = red;
  endtask

  task automatic expect_out(input string nm, input bit sel, input logic [4:0] ctl,
                            input logic [31:0] cnt);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.ctl  = ctl;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  exp_t        mon_e;
  logic [4:0]  act_ctl;
  logic [31:0] act_cnt;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.sel) begin
        act_ctl = {s_if.pc_write, s_if.if_id_write, s_if.if_id_flush,
                   s_if.id_ex_flush, s_if.halted};
        act_cnt = 32'(s_if.stall_cnt);
      end else begin
        act_ctl = {m_if.pc_write, m_if.if_id_write, m_if.if_id_flush,
                   m_if.id_ex_flush, m_if.halted};
        act_cnt = m_if.stall_cnt;
      end
      n_total++;
      if ((act_ctl === mon_e.ctl) && (act_cnt === mon_e.cnt)) begin
        n_pass++;
        $display("ok   %s: ctl=%b cnt=%0d", mon_e.name, act_ctl, act_cnt);
      end else begin
        $display("FAIL %s: got ctl=%b cnt=%0d, required ctl=%b cnt=%0d",
                 mon_e.name, act_ctl, act_cnt, mon_e.ctl, mon_e.cnt);
      end
    end
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    drv_m(0, 0, 0, 0, 0, 0, 0, 0);
    drv_s(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    drv_m(0, 0, 0, 0, 0, 0, 0, 0); expect_out("reset_idle",   0, NORM,  0); cyc();
    drv_m(1, 0, 0, 0, 1, 1, 0, 0); expect_out("x0_immune",    0, NORM,  0); cyc();
    drv_m(1, 3, 5, 0, 1, 1, 5, 0); expect_out("luse_rs2",     0, STALL, 0); cyc();
    drv_m(1, 3, 5, 0, 1, 0, 5, 0); expect_out("after_luse",   0, NORM,  1); cyc();
    drv_m(1, 7, 0, 0, 1, 1, 7, 0); expect_out("luse_rs1",     0, STALL, 1); cyc();
    drv_m(0, 7, 0, 0, 1, 1, 7, 0); expect_out("no_id_valid",  0, NORM,  2); cyc();
    drv_m(1, 7, 0, 0, 0, 1, 7, 0); expect_out("no_ex_valid",  0, NORM,  2); cyc();
    drv_m(1, 3, 5, 1, 1, 1, 5, 1); expect_out("redirect_wins", 0, REDIR, 2); cyc();
    for (int i = 0; i < 10; i++) begin
      drv_m(0, 0, 0, 0, 0, 0, 0, 0); expect_out("post_redirect", 0, NORM, 2); cyc();
    end

    // Halt held behind a load-use: stall first, accept next cycle.
    drv_m(1, 3, 5, 1, 1, 1, 5, 0); expect_out("halt_under_luse", 0, STALL, 2); cyc();
    drv_m(1, 3, 5, 1, 1, 0, 5, 0); expect_out("halt_accept",     0, STALL, 3); cyc();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drv_m(1, 3, 5, 1, 1, 1, 5, 1);
      else        drv_m(0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("drain", 0, DRN, 3); cyc();
    end
    for (int i = 0; i < 20; i++) begin
      drv_m(1, 3, 5, 1, 1, logic'(i % 3 == 0), 5, logic'(i % 2 == 0));
      expect_out("halted", 0, HLT, 3); cyc();
    end

    rst = 1'b1;
    drv_m(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    expect_out("reset_from_halted", 0, NORM, 0); cyc();
    drv_m(1, 3, 5, 0, 1, 1, 5, 0); expect_out("luse_again",   0, STALL, 0); cyc();
    drv_m(1, 0, 0, 1, 0, 0, 0, 0); expect_out("halt_accept2", 0, STALL, 1); cyc();
    drv_m(0, 0, 0, 0, 0, 0, 0, 0); expect_out("drain2",       0, DRN,   1); cyc();
    rst = 1'b1;                    expect_out("drain2_rst",   0, DRN,   1); cyc();
    rst = 1'b0;                    expect_out("after_mid_drain_rst", 0, NORM, 0); cyc();
    for (int i = 0; i < 5; i++) begin
      expect_out("run_after_rst", 0, NORM, 0); cyc();
    end

    // Saturation on the 4-bit counter instance.
    for (int i = 0; i < 20; i++) begin
      drv_s(1, 9, 2, 0, 1, 1, 9, 0);
      expect_out("sat_luse", 1, STALL, (i < 15) ? 32'(i) : 32'd15); cyc();
    end
    drv_s(0, 0, 0, 0, 0, 0, 0, 0); expect_out("sat_hold", 1, NORM, 15); cyc();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total + exp_q.size());
    $finish;
  end

endmodule

// File: doc/hazard_halt_ctrl.md
Name: hazard_halt_ctrl

Overview:
- Pipeline-control responder that consumes the decoded ID-stage control signals (MemRead, RegWrite, halt and register indices) together with EX-stage status.
- Produces PC/IF-ID write enables and flush/bubble controls for the 5-stage RV32I pipeline.
- Owns load-use stall detection, control-redirect flushing and the halt drain sequence (ECALL/EBREAK/FENCE).
- Keeps a saturating stall-cycle performance counter.

Parameters:
- DRAIN_CYCLES, 3: cycles spent bubbling after a halt is accepted, so EX/MEM/WB retire; legal range 1..15.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_halt  in  1  decoded halt from the control unit for the ID instruction
- ex_valid  in  1  EX stage holds a real instruction
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID register load enable
- if_id_flush  out  1  zero IF/ID (inject NOP)
- id_ex_flush  out  1  zero ID/EX control fields (inject bubble)
- halted  out  1  core fully stopped
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Registered state: fsm in {RUN, DRAIN, HALTED}, drain counter dcnt[3:0], stall_cnt. Control outputs are combinational from fsm and the inputs.
- Reset (rst=1 at a clock edge) sets fsm=RUN, dcnt=0, stall_cnt=0. While fsm=RUN with no hazard: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0, halted=0.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge; no other exit from HALTED exists.
- luse = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1)|(ex_rd==id_rs2)).
- In RUN, priority is redirect > load-use > halt > normal.
- ex_redirect=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1. The ID instruction is wrong-path, so a simultaneous id_halt or luse is ignored and fsm stays RUN.
- luse=1, no redirect: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0. This is exactly one bubble because the load advances next cycle.
  - stall_cnt increments by 1, saturating at all-ones.
  - A halting instruction held in ID under luse is not accepted that cycle; it is accepted on the following cycle.
- id_valid & id_halt, no redirect, no luse: the halt instruction itself enters EX as a bubble.
  - Outputs: id_ex_flush=1, pc_write=0, if_id_write=0.
  - Next state: fsm <= DRAIN, dcnt <= DRAIN_CYCLES-1.
- DRAIN: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1; ex_redirect and luse are ignored.
  - dcnt decrements each cycle; in the cycle dcnt==0, fsm <= HALTED.
  - Total DRAIN residency is DRAIN_CYCLES cycles.
- HALTED: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, halted=1. All inputs are ignored.
- stall_cnt counts only load-use stalls; drain and halt cycles are not counted.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the fsm state enum (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2);
  - the x0 register constant REG_ZERO=5'd0;
  - the default DRAIN_CYCLES value.
- One sub-module is natural: load_use_detect (combinational luse comparator), reused later for forwarding checks.
- The FSM and counters stay in the top module.

Test Plan:
- Load-use stall: ex_valid=1, ex_mem_read=1, ex_rd=5, id_valid=1, id_rs2=5 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt goes 0->1; next cycle with ex_mem_read=0, outputs return to 1/1/0/0.
- x0 immunity: same as the load-use case but ex_rd=0, id_rs1=0 -> no stall, pc_write=1, stall_cnt stays 0.
- Redirect beats halt and luse: ex_redirect=1, id_halt=1, luse true in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; fsm stays RUN; halted stays 0 for 10 cycles.
- Halt drain: id_valid=1, id_halt=1 at cycle t -> DRAIN during t+1..t+3 (DRAIN_CYCLES=3) with pc_write=0; halted=1 from t+4 onward and stays 1 for 20 cycles despite ex_redirect pulses.
- Reset mid-drain: assert rst at t+2 of the halt drain -> next cycle fsm=RUN, halted=0, pc_write=1, stall_cnt=0.
- Counter saturation: CNT_W=4, hold luse for 20 cycles -> stall_cnt reaches 15 and stays at 15.
